// File: rtl/health_pkg.sv
// Shared health-check definitions: mode encodings and signed-difference magnitude helper.
// Combinational only; no state or handshakes.
// Reused by the health-check datapath blocks.
package health_pkg;

  localparam logic MODE_ABS = 1'b0;
  localparam logic MODE_DEV = 1'b1;

  // Widest difference the helper handles; callers size-cast in and out.
  localparam int MAG_MAX_W = 64;

  // |d| of a signed value; the result is one bit narrower and always fits
  // because the caller's difference never reaches the most negative code.
  function automatic logic [MAG_MAX_W-1:0] mag_abs(input logic signed [MAG_MAX_W:0] d);
    logic signed [MAG_MAX_W:0] neg;
    neg = -d;
    return d[MAG_MAX_W] ? neg[MAG_MAX_W-1:0] : d[MAG_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/abs_pipe_stage.sv
// Generic valid/ready register slice carrying DW bits of data.
// Latency 1 cycle; full throughput.
// Backpressure: holds its content while i_rdy is low; o_rdy = empty or draining.
module abs_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [DW-1:0] o_dat
);

  logic          r_vld;
  logic [DW-1:0] r_dat;

  assign o_rdy = ~r_vld | i_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_dat;

  // Data only loads on a real transfer so an idle slice keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_dat <= i_dat;
      end
    end
  end

endmodule

// File: rtl/abs_deviation_tracker.sv
// Signed sample -> unsigned magnitude (|x| or |x - baseline|) with peak hold and debounced alarm.
// Latency 2 cycles, 1 sample/cycle; peak/alarm update one edge after each output transfer.
// Backpressure: two-slice pipeline buffers 2 samples; in_ready drops combinationally on out_ready.
module abs_deviation_tracker
  import health_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ALARM_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] baseline,
  input  logic [WIDTH-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_magnitude,
  output logic [WIDTH-1:0] peak,
  input  logic             peak_clear,
  output logic             alarm
);

  localparam int DW = WIDTH + 1;
  localparam int CW = $clog2(ALARM_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ALARM_COUNT);

  logic signed [DW-1:0]        w_samp_x;
  logic signed [DW-1:0]        w_base_x;
  logic signed [DW-1:0]        w_s1_in_dat;
  logic signed [DW-1:0]        w_s1_dat;
  logic                        w_s1_vld;
  logic                        w_s2_rdy;
  logic signed [MAG_MAX_W:0]   w_d_ext;
  logic [WIDTH-1:0]            w_s2_in_dat;
  logic                        w_xfer;
  logic                        w_over;
  logic [CW-1:0]               w_cnt_nxt;

  logic [CW-1:0]               r_cnt;
  logic                        r_alarm;
  logic [WIDTH-1:0]            r_peak;

  // Stage 1: one-bit-wider signed difference, so mode 1 can never overflow.
  assign w_samp_x    = {in_sample[WIDTH-1], in_sample};
  assign w_base_x    = {baseline[WIDTH-1], baseline};
  assign w_s1_in_dat = (in_mode == MODE_DEV) ? (w_samp_x - w_base_x) : w_samp_x;

  abs_pipe_stage #(.DW(DW)) u_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (in_valid),
    .o_rdy (in_ready),
    .i_dat (w_s1_in_dat),
    .o_vld (w_s1_vld),
    .i_rdy (w_s2_rdy),
    .o_dat (w_s1_dat)
  );

  assign w_d_ext     = (MAG_MAX_W + 1)'(w_s1_dat);
  assign w_s2_in_dat = WIDTH'(mag_abs(w_d_ext));

  abs_pipe_stage #(.DW(WIDTH)) u_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_s1_vld),
    .o_rdy (w_s2_rdy),
    .i_dat (w_s2_in_dat),
    .o_vld (out_valid),
    .i_rdy (out_ready),
    .o_dat (out_magnitude)
  );

  assign w_xfer = out_valid & out_ready;
  assign w_over = out_magnitude > threshold;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_xfer) begin
      if (!w_over) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_alarm <= (w_cnt_nxt == CNT_MAX);
    end
  end

  // A clear that coincides with a transfer restarts the peak from that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (peak_clear) begin
      r_peak <= w_xfer ? out_magnitude : '0;
    end else if (w_xfer && (out_magnitude > r_peak)) begin
      r_peak <= out_magnitude;
    end
  end

  assign peak  = r_peak;
  assign alarm = r_alarm;

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_magnitude)));

endmodule

// File: tb/tb_abs_deviation_tracker.sv
// Scoreboarded bench for abs_deviation_tracker (WIDTH=8, ALARM_COUNT=4).
module tb_abs_deviation_tracker;

  localparam int W  = 8;
  localparam int AC = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_sample;
  logic                in_mode;
  logic signed [W-1:0] baseline;
  logic [W-1:0]        threshold;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_magnitude;
  logic [W-1:0]        peak;
  logic                peak_clear;
  logic                alarm;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [W-1:0] exp_q[$];

  abs_deviation_tracker #(.WIDTH(W), .ALARM_COUNT(AC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sample     (in_sample),
    .in_mode       (in_mode),
    .baseline      (baseline),
    .threshold     (threshold),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_magnitude (out_magnitude),
    .peak          (peak),
    .peak_clear    (peak_clear),
    .alarm         (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic signed [W-1:0] s, input logic m,
                                         input logic signed [W-1:0] b);
    int d;
    d = m ? (int'(s) - int'(b)) : int'(s);
    if (d < 0) d = -d;
    return d[W-1:0];
  endfunction

  // Inputs are stable from posedge+1, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sample, in_mode, baseline));
      end
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("sb_mag", out_magnitude, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic m, input int b);
    in_valid  = 1'b1;
    in_sample = W'(s);
    in_mode   = m;
    baseline  = W'(b);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int out_before;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sample  = '0;
    in_mode    = 1'b0;
    baseline   = '0;
    threshold  = 8'hFF;
    out_ready  = 1'b1;
    peak_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_mag", out_magnitude, 0);
    check("rst_peak", peak, 0);
    check("rst_alarm", alarm, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Mode 0 extremes, streamed at full rate.
    drive(-128, 1'b0, 0);
    check("lat_e1_vld", out_valid, 0);
    drive(127, 1'b0, 0);
    check("lat_e2_vld", out_valid, 1);
    check("lat_e2_mag", out_magnitude, 128);
    drive(0, 1'b0, 0);
    drive(-1, 1'b0, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    check("peak_m0", peak, 128);
    check("idle_vld", out_valid, 0);

    // Mode 1 deviation extremes.
    drive(-128, 1'b1, 127);
    drive(127, 1'b1, 127);
    drive(127, 1'b1, -128);
    in_valid = 1'b0;
    repeat (3) tick();
    check("peak_m1", peak, 255);
    check("alarm_quiet", alarm, 0);

    // Stall: two samples buffered, third refused.
    out_before = n_out;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_mode    = 1'b0;
    in_sample  = 8'sd3;
    #1 check("stall_rdy0", in_ready, 1);
    tick();
    in_sample = -8'sd4;
    #1 check("stall_rdy1", in_ready, 1);
    tick();
    in_sample = 8'sd5;
    #1 check("stall_rdy2", in_ready, 0);
    check("stall_vld", out_valid, 1);
    tick();
    tick();
    check("stall_hold_mag", out_magnitude, 3);
    check("stall_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    #1 check("rdy_comb", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("stall_outs", n_out - out_before, 3);
    check("stall_drain", exp_q.size(), 0);

    // Debounced alarm.
    threshold = 8'd10;
    drive(11, 1'b0, 0);
    drive(12, 1'b0, 0);
    drive(13, 1'b0, 0);
    drive(14, 1'b0, 0);
    check("alarm_e4", alarm, 0);
    drive(10, 1'b0, 0);
    check("alarm_e5", alarm, 0);
    in_valid = 1'b0;
    tick();
    check("alarm_rise", alarm, 1);
    tick();
    check("alarm_fall", alarm, 0);
    repeat (2) tick();
    threshold = 8'hFF;

    // Peak clear alone and coincident with a transfer.
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    check("peak_clr", peak, 0);
    drive(50, 1'b0, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    check("peak_50", peak, 50);
    out_ready = 1'b0;
    drive(-20, 1'b0, 0);
    in_valid = 1'b0;
    tick();
    check("peak_pre", peak, 50);
    peak_clear = 1'b1;
    out_ready  = 1'b1;
    tick();
    peak_clear = 1'b0;
    check("peak_clr_xfer", peak, 20);
    tick();
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    check("peak_clr2", peak, 0);

    // Reset mid-stream with a stalled result.
    threshold = 8'd0;
    repeat (4) drive(7, 1'b0, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    check("pre_rst_alarm", alarm, 1);
    check("pre_rst_peak", peak, 7);
    out_ready = 1'b0;
    drive(9, 1'b0, 0);
    drive(-9, 1'b0, 0);
    in_valid = 1'b0;
    check("pre_rst_vld", out_valid, 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mrst_out_valid", out_valid, 0);
    check("mrst_mag", out_magnitude, 0);
    check("mrst_peak", peak, 0);
    check("mrst_alarm", alarm, 0);
    check("mrst_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n     = 1'b1;
    threshold = 8'hFF;
    out_ready = 1'b1;
    drive(-5, 1'b0, 0);
    check("post_rst_e1", out_valid, 0);
    in_valid = 1'b0;
    tick();
    check("post_rst_vld", out_valid, 1);
    check("post_rst_mag", out_magnitude, 5);
    repeat (3) tick();
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
